// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: bus widths,
// load/store codes, controller states and the access-size byte mask.
package mem_access_ctrl_pkg;

  localparam int AddrWidth = 32;
  localparam int DataWidth = 32;

  localparam logic [2:0] RdNoExec     = 3'b000;
  localparam logic [2:0] RdSignByte   = 3'b001;
  localparam logic [2:0] RdUnsignByte = 3'b010;
  localparam logic [2:0] RdSignHalf   = 3'b011;
  localparam logic [2:0] RdUnsignHalf = 3'b100;
  localparam logic [2:0] RdReadWord   = 3'b101;

  localparam logic [1:0] WrNone      = 2'b00;
  localparam logic [1:0] WrByte      = 2'b01;
  localparam logic [1:0] WrHalf      = 2'b10;
  localparam logic [1:0] WrWriteWord = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } ctrlStateT;

  // Keeps only the bytes a store of the given size actually writes.
  function automatic logic [DataWidth-1:0] sizeMask(input logic [2:0] size);
    case (size)
      3'd1:    return {{(DataWidth-8){1'b0}}, 8'hFF};
      3'd2:    return {{(DataWidth-16){1'b0}}, 16'hFFFF};
      3'd4:    return {DataWidth{1'b1}};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_req_check.sv
// Combinational request decode: access size in bytes and the legality of the
// code pair, alignment and address range.
module mem_req_check
  import mem_access_ctrl_pkg::*;
#(
  parameter int RAMLENGTH = 10
) (
  input  logic [2:0]           reqRead,
  input  logic [1:0]           reqWrite,
  input  logic [AddrWidth-1:0] reqAddr,
  output logic                 illegal,
  output logic [2:0]           size
);

  localparam logic [AddrWidth:0] RamLimit = (AddrWidth+1)'(RAMLENGTH);

  logic               codeBad;
  logic               alignBad;
  logic [AddrWidth:0] lastByte;

  always_comb begin
    size    = 3'd0;
    codeBad = ((reqRead != RdNoExec) == (reqWrite != WrNone));
    case (reqRead)
      RdNoExec: begin
        case (reqWrite)
          WrByte:      size = 3'd1;
          WrHalf:      size = 3'd2;
          WrWriteWord: size = 3'd4;
          default:     size = 3'd0;
        endcase
      end
      RdSignByte, RdUnsignByte: size = 3'd1;
      RdSignHalf, RdUnsignHalf: size = 3'd2;
      RdReadWord:               size = 3'd4;
      default:                  codeBad = 1'b1;
    endcase

    alignBad = ((size == 3'd2) && reqAddr[0]) ||
               ((size == 3'd4) && (reqAddr[1:0] != 2'b00));

    // One extra bit so an access running past the top of the address space
    // lands above RamLimit instead of wrapping back into range.
    lastByte = {1'b0, reqAddr} + (AddrWidth+1)'(size) - (AddrWidth+1)'(1);

    illegal = codeBad || alignBad || (lastByte >= RamLimit);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding data-memory access controller: accepts a load/store,
// drives the memory bus for one cycle and returns a one-cycle response.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int RAMLENGTH = 10
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  input  logic                 ReqValid,
  output logic                 ReqReady,
  input  logic [2:0]           ReqRead,
  input  logic [1:0]           ReqWrite,
  input  logic [AddrWidth-1:0] ReqAddr,
  input  logic [DataWidth-1:0] ReqWData,
  output logic                 RespValid,
  output logic [DataWidth-1:0] RespData,
  output logic                 RespErr,
  output logic [AddrWidth-1:0] MemAddr,
  output logic [DataWidth-1:0] MemDataIn,
  output logic [2:0]           Read,
  output logic [1:0]           Write,
  input  logic [DataWidth-1:0] MemDataOut
);

  // state  | meaning
  // IDLE   | no request in flight, ready to accept
  // ACCESS | bus driven for one cycle, memory samples on the falling edge
  // RESP   | response pulse out, can accept the next request

  ctrlStateT            state, stateNxt;
  logic                 accept;
  logic                 reqIllegal;
  logic [2:0]           reqSize;
  logic                 respValidNxt, respErrNxt;
  logic [DataWidth-1:0] respDataNxt, memDataInNxt;
  logic [AddrWidth-1:0] memAddrNxt;
  logic [2:0]           readNxt;
  logic [1:0]           writeNxt;

  mem_req_check #(.RAMLENGTH(RAMLENGTH)) uReqCheck (
    .reqRead  (ReqRead),
    .reqWrite (ReqWrite),
    .reqAddr  (ReqAddr),
    .illegal  (reqIllegal),
    .size     (reqSize)
  );

  assign ReqReady = (state != ACCESS);
  assign accept   = ReqValid && ReqReady;

  always_comb begin
    stateNxt     = state;
    respValidNxt = 1'b0;
    respErrNxt   = 1'b0;
    respDataNxt  = '0;
    memAddrNxt   = '0;
    memDataInNxt = '0;
    readNxt      = RdNoExec;
    writeNxt     = WrNone;
    case (state)
      ACCESS: begin
        stateNxt     = RESP;
        respValidNxt = 1'b1;
        respDataNxt  = (Read != RdNoExec) ? MemDataOut : '0;
      end
      default: begin
        if (accept && reqIllegal) begin
          stateNxt     = RESP;
          respValidNxt = 1'b1;
          respErrNxt   = 1'b1;
        end else if (accept) begin
          stateNxt     = ACCESS;
          readNxt      = ReqRead;
          writeNxt     = ReqWrite;
          memAddrNxt   = ReqAddr;
          memDataInNxt = ReqWData & sizeMask(reqSize);
        end else begin
          stateNxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      RespValid <= 1'b0;
      RespErr   <= 1'b0;
      RespData  <= '0;
      MemAddr   <= '0;
      MemDataIn <= '0;
      Read      <= RdNoExec;
      Write     <= WrNone;
    end else begin
      state     <= stateNxt;
      RespValid <= respValidNxt;
      RespErr   <= respErrNxt;
      RespData  <= respDataNxt;
      MemAddr   <= memAddrNxt;
      MemDataIn <= memDataInNxt;
      Read      <= readNxt;
      Write     <= writeNxt;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a big-endian byte memory model that
// samples on the falling edge and applies sign/zero extension by load code.
module tb_mem_access_ctrl;

  localparam int RamLen = 10;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic [2:0]  ReqRead = 3'd0;
  logic [1:0]  ReqWrite = 2'd0;
  logic [31:0] ReqAddr = 32'd0;
  logic [31:0] ReqWData = 32'd0;
  logic        RespValid;
  logic [31:0] RespData;
  logic        RespErr;
  logic [31:0] MemAddr;
  logic [31:0] MemDataIn;
  logic [2:0]  Read;
  logic [1:0]  Write;
  logic [31:0] MemDataOut = 32'd0;

  int nAsserts = 0;
  int nFail = 0;

  logic [7:0] mem [RamLen];

  mem_access_ctrl #(.RAMLENGTH(RamLen)) dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqRead    (ReqRead),
    .ReqWrite   (ReqWrite),
    .ReqAddr    (ReqAddr),
    .ReqWData   (ReqWData),
    .RespValid  (RespValid),
    .RespData   (RespData),
    .RespErr    (RespErr),
    .MemAddr    (MemAddr),
    .MemDataIn  (MemDataIn),
    .Read       (Read),
    .Write      (Write),
    .MemDataOut (MemDataOut)
  );

  always #5 clk1 = ~clk1;

  // Memory model: writes and read data both resolve on the falling edge.
  always @(negedge clk1) begin
    int a;
    a = int'(MemAddr);
    if (a >= 0 && a + 3 < RamLen + 3) begin
      case (Write)
        2'd1: if (a < RamLen) mem[a] = MemDataIn[7:0];
        2'd2: if (a + 1 < RamLen) begin mem[a] = MemDataIn[15:8]; mem[a+1] = MemDataIn[7:0]; end
        2'd3: if (a + 3 < RamLen) begin
          mem[a] = MemDataIn[31:24]; mem[a+1] = MemDataIn[23:16];
          mem[a+2] = MemDataIn[15:8]; mem[a+3] = MemDataIn[7:0];
        end
        default: ;
      endcase
      case (Read)
        3'd1: if (a < RamLen) MemDataOut = {{24{mem[a][7]}}, mem[a]};
        3'd2: if (a < RamLen) MemDataOut = {24'd0, mem[a]};
        3'd3: if (a + 1 < RamLen) MemDataOut = {{16{mem[a][7]}}, mem[a], mem[a+1]};
        3'd4: if (a + 1 < RamLen) MemDataOut = {16'd0, mem[a], mem[a+1]};
        3'd5: if (a + 3 < RamLen) MemDataOut = {mem[a], mem[a+1], mem[a+2], mem[a+3]};
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic drive(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                       input logic [31:0] wd);
    ReqValid = 1'b1;
    ReqRead  = rd;
    ReqWrite = wr;
    ReqAddr  = addr;
    ReqWData = wd;
  endtask

  task automatic doLegal(input string tag, input logic [2:0] rd, input logic [1:0] wr,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] expData);
    drive(rd, wr, addr, wd);
    chk({tag, ".readyPre"}, ReqReady, 1);
    tick();
    ReqValid = 1'b0;
    ReqWData = 32'hDEAD_0000;
    chk({tag, ".readyAcc"}, ReqReady, 0);
    chk({tag, ".validAcc"}, RespValid, 0);
    chk({tag, ".readAcc"}, Read, rd);
    chk({tag, ".writeAcc"}, Write, wr);
    chk({tag, ".addrAcc"}, MemAddr, addr);
    tick();
    chk({tag, ".valid"}, RespValid, 1);
    chk({tag, ".err"}, RespErr, 0);
    chk({tag, ".data"}, RespData, expData);
    chk({tag, ".readResp"}, Read, 0);
    chk({tag, ".writeResp"}, Write, 0);
    chk({tag, ".addrResp"}, MemAddr, 0);
    tick();
    chk({tag, ".validIdle"}, RespValid, 0);
  endtask

  task automatic doIllegal(input string tag, input logic [2:0] rd, input logic [1:0] wr,
                           input logic [31:0] addr);
    drive(rd, wr, addr, 32'hFFFF_FFFF);
    tick();
    ReqValid = 1'b0;
    chk({tag, ".valid"}, RespValid, 1);
    chk({tag, ".err"}, RespErr, 1);
    chk({tag, ".data"}, RespData, 0);
    chk({tag, ".read"}, Read, 0);
    chk({tag, ".write"}, Write, 0);
    chk({tag, ".ready"}, ReqReady, 1);
    tick();
    chk({tag, ".validIdle"}, RespValid, 0);
    chk({tag, ".readIdle"}, Read, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rdT [5];
    logic [1:0]  wrT [5];
    logic [31:0] adT [5];
    logic [31:0] wdT [5];
    logic [31:0] exT [5];

    for (int i = 0; i < RamLen; i++) mem[i] = 8'h00;

    tick();
    chk("rst.ready", ReqReady, 1);
    chk("rst.valid", RespValid, 0);
    chk("rst.err", RespErr, 0);
    chk("rst.data", RespData, 0);
    chk("rst.read", Read, 0);
    chk("rst.write", Write, 0);
    chk("rst.addr", MemAddr, 0);
    chk("rst.wdata", MemDataIn, 0);
    tick();
    rst_n = 1'b1;

    drive(3'd0, 2'd3, 32'd0, 32'h1122_3344);
    tick();
    ReqValid = 1'b0;
    chk("sw0.memData", MemDataIn, 32'h1122_3344);
    tick();
    chk("sw0.valid", RespValid, 1);
    chk("sw0.err", RespErr, 0);
    chk("sw0.data", RespData, 0);
    tick();

    doLegal("lw0", 3'd5, 2'd0, 32'd0, 32'd0, 32'h1122_3344);
    doLegal("lbs0", 3'd1, 2'd0, 32'd0, 32'd0, 32'h0000_0011);
    doLegal("sb1", 3'd0, 2'd1, 32'd1, 32'h0000_0080, 32'd0);
    doLegal("lbs1", 3'd1, 2'd0, 32'd1, 32'd0, 32'hFFFF_FF80);
    doLegal("lbu1", 3'd2, 2'd0, 32'd1, 32'd0, 32'h0000_0080);

    doIllegal("lhsMis", 3'd3, 2'd0, 32'd1);
    doIllegal("lwOob8", 3'd5, 2'd0, 32'd8);
    doLegal("lw4", 3'd5, 2'd0, 32'd4, 32'd0, 32'd0);
    doIllegal("bothIdle", 3'd0, 2'd0, 32'd0);
    doIllegal("bothAct", 3'd5, 2'd3, 32'd0);
    doIllegal("badCode", 3'd6, 2'd0, 32'd0);
    doIllegal("lwMis2", 3'd5, 2'd0, 32'd2);
    doIllegal("lwWrap", 3'd5, 2'd0, 32'hFFFF_FFFC);
    doIllegal("sbOob10", 3'd0, 2'd1, 32'd10);
    doLegal("lhu8", 3'd4, 2'd0, 32'd8, 32'd0, 32'd0);

    rdT = '{3'd0, 3'd5, 3'd0, 3'd4, 3'd3};
    wrT = '{2'd3, 2'd0, 2'd2, 2'd0, 2'd0};
    adT = '{32'd4, 32'd4, 32'd8, 32'd8, 32'd8};
    wdT = '{32'hA5B6_C7D8, 32'd0, 32'h0000_BEEF, 32'd0, 32'd0};
    exT = '{32'd0, 32'hA5B6_C7D8, 32'd0, 32'h0000_BEEF, 32'hFFFF_BEEF};
    for (int i = 0; i < 5; i++) begin
      drive(rdT[i], wrT[i], adT[i], wdT[i]);
      chk($sformatf("b2b%0d.readyPre", i), ReqReady, 1);
      tick();
      chk($sformatf("b2b%0d.readyAcc", i), ReqReady, 0);
      chk($sformatf("b2b%0d.validAcc", i), RespValid, 0);
      tick();
      chk($sformatf("b2b%0d.valid", i), RespValid, 1);
      chk($sformatf("b2b%0d.err", i), RespErr, 0);
      chk($sformatf("b2b%0d.data", i), RespData, exT[i]);
    end
    ReqValid = 1'b0;
    tick();
    chk("b2b.validEnd", RespValid, 0);
    chk("b2b.readyEnd", ReqReady, 1);

    drive(3'd5, 2'd0, 32'd0, 32'd0);
    tick();
    ReqValid = 1'b0;
    chk("rstAcc.readPre", Read, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstAcc.read", Read, 0);
    chk("rstAcc.write", Write, 0);
    chk("rstAcc.addr", MemAddr, 0);
    chk("rstAcc.valid", RespValid, 0);
    tick();
    chk("rstAcc.valid1", RespValid, 0);
    tick();
    chk("rstAcc.valid2", RespValid, 0);
    rst_n = 1'b1;
    doLegal("lwAfterRst", 3'd5, 2'd0, 32'd0, 32'd0, 32'h1180_3344);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
